// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_pkg
// Brief    : Shared types and helpers for the code lock controller: the FSM
//            state encoding and the timer width calculation.
// Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    // Controller states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        SUCCESS = 3'd2,
        ERROR   = 3'd3,
        PROG    = 3'd4,
        LOCKOUT = 3'd5
    } lock_state_t;

    // Width of one down-counter able to hold the largest of three loads.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_timer
// Brief    : Loadable down-counter that stops at zero, with a zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_value;

    // Load has priority over counting; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_tick && (r_value != '0)) begin
            r_value <= r_value - WIDTH'(1);
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_ctrl
// Brief    : Keypad code lock. Collects CODE_LEN keys, unlocks on a match,
//            allows reprogramming while unlocked, counts consecutive
//            failures. Optional lockout after MAX_FAIL failures is enabled
//            with the macro CODE_LOCK_LOCKOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                          CODE_LEN      = 4,
    parameter int                          KEY_W         = 4,
    parameter logic [CODE_LEN*KEY_W-1:0]   DEFAULT_CODE  = {4'h1, 4'h5, 4'h7, 4'hF},
    parameter int                          ENTRY_TIMEOUT = 10,
    parameter int                          UNLOCK_TIME   = 10,
    parameter int                          MAX_FAIL      = 3,
    parameter int                          LOCKOUT_TIME  = 50
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [KEY_W-1:0]              key,
    input  logic                          key_valid,
    input  logic                          prog_req,
    output logic                          unlock,
    output logic                          green_led,
    output logic                          red_led,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int c_tmr_w  = timer_width(ENTRY_TIMEOUT, UNLOCK_TIME, LOCKOUT_TIME);
    localparam int c_idx_w  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int c_fc_w   = $clog2(MAX_FAIL + 1);
    localparam int c_code_w = CODE_LEN * KEY_W;

    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(CODE_LEN - 1);
    localparam logic [c_fc_w-1:0]  c_fail_max  = c_fc_w'(MAX_FAIL);
    localparam logic [c_tmr_w-1:0] c_t_entry   = c_tmr_w'(ENTRY_TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_t_unlock  = c_tmr_w'(UNLOCK_TIME);
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam logic [c_tmr_w-1:0] c_t_lockout = c_tmr_w'(LOCKOUT_TIME);
`endif

    lock_state_t         r_state, w_state_next;
    logic [c_idx_w-1:0]  r_index, w_index_next;
    logic                r_mismatch, w_mismatch_next;
    logic [c_fc_w-1:0]   r_fail_cnt, w_fail_next, w_fail_inc;
    logic [c_code_w-1:0] r_code, w_code_next;
    logic [c_code_w-1:0] r_shadow, w_shadow_next;
    logic [KEY_W-1:0]    w_slot, w_slot0;
    logic                w_mm_acc;

    logic                w_tmr_load, w_tmr_tick, w_tmr_zero, w_tmr_expire;
    logic [c_tmr_w-1:0]  w_tmr_load_val, w_tmr_value;

    code_lock_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_tick     (w_tmr_tick),
        .o_value    (w_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    // A timed state lasts exactly N cycles: leave on the cycle the count would reach 0.
    assign w_tmr_tick   = (r_state != IDLE);
    assign w_tmr_expire = w_tmr_zero | (w_tmr_value == c_tmr_w'(1));

    // Slot 0 lives in the most significant key position.
    assign w_slot0    = r_code[c_code_w-1 -: KEY_W];
    assign w_slot     = r_code[(CODE_LEN - 1 - int'(r_index)) * KEY_W +: KEY_W];
    assign w_mm_acc   = r_mismatch | (key != w_slot);
    assign w_fail_inc = (r_fail_cnt == c_fail_max) ? r_fail_cnt : r_fail_cnt + c_fc_w'(1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Entry index, mismatch flag, failure count and code storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_mismatch <= 1'b0;
            r_fail_cnt <= '0;
            r_code     <= DEFAULT_CODE;
            r_shadow   <= '0;
        end else begin
            r_index    <= w_index_next;
            r_mismatch <= w_mismatch_next;
            r_fail_cnt <= w_fail_next;
            r_code     <= w_code_next;
            r_shadow   <= w_shadow_next;
        end
    end

    // Next-state and datapath update; keys are only consumed in IDLE, ENTRY and PROG.
    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_mismatch_next = r_mismatch;
        w_fail_next     = r_fail_cnt;
        w_code_next     = r_code;
        w_shadow_next   = r_shadow;
        w_tmr_load      = 1'b0;
        w_tmr_load_val  = '0;
        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_mismatch_next = (key != w_slot0);
                    w_index_next    = c_idx_w'(1);
                    w_tmr_load      = 1'b1;
                    w_tmr_load_val  = c_t_entry;
                    w_state_next    = ENTRY;
                end
            end
            ENTRY: begin
                // A key on the expiry cycle takes priority over the timeout.
                if (key_valid) begin
                    if (r_index == c_idx_last) begin
                        w_index_next    = '0;
                        w_mismatch_next = 1'b0;
                        if (w_mm_acc) begin
                            w_fail_next  = w_fail_inc;
                            w_state_next = ERROR;
                        end else begin
                            w_fail_next    = '0;
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = c_t_unlock;
                            w_state_next   = SUCCESS;
                        end
                    end else begin
                        w_mismatch_next = w_mm_acc;
                        w_index_next    = r_index + c_idx_w'(1);
                        w_tmr_load      = 1'b1;
                        w_tmr_load_val  = c_t_entry;
                    end
                end else if (w_tmr_expire) begin
                    w_index_next    = '0;
                    w_mismatch_next = 1'b0;
                    w_fail_next     = w_fail_inc;
                    w_state_next    = ERROR;
                end
            end
            SUCCESS: begin
                if (prog_req) begin
                    w_index_next   = '0;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = c_t_entry;
                    w_state_next   = PROG;
                end else if (w_tmr_expire) begin
                    w_state_next = IDLE;
                end
            end
            ERROR: begin
`ifdef CODE_LOCK_LOCKOUT_EN
                if (r_fail_cnt == c_fail_max) begin
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = c_t_lockout;
                    w_state_next   = LOCKOUT;
                end else begin
                    w_state_next = IDLE;
                end
`else
                w_state_next = IDLE;
`endif
            end
            PROG: begin
                if (key_valid) begin
                    w_shadow_next[(CODE_LEN - 1 - int'(r_index)) * KEY_W +: KEY_W] = key;
                    if (r_index == c_idx_last) begin
                        // Whole new code becomes active in a single cycle.
                        w_code_next  = w_shadow_next;
                        w_index_next = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_index_next   = r_index + c_idx_w'(1);
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = c_t_entry;
                    end
                end else if (w_tmr_expire) begin
                    // Abandoned programming: shadow is simply never committed.
                    w_index_next = '0;
                    w_state_next = IDLE;
                end
            end
`ifdef CODE_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (w_tmr_expire) begin
                    w_fail_next  = '0;
                    w_state_next = IDLE;
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign unlock    = (r_state == SUCCESS);
    assign green_led = (r_state == SUCCESS) | (r_state == PROG);
    assign fail_cnt  = r_fail_cnt;
`ifdef CODE_LOCK_LOCKOUT_EN
    assign red_led    = (r_state == ERROR) | (r_state == LOCKOUT);
    assign locked_out = (r_state == LOCKOUT);
`else
    assign red_led    = (r_state == ERROR);
    assign locked_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_ctrl
// Brief    : Directed self-checking bench for code_lock_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic       key_valid;
    logic       prog_req;
    logic       unlock;
    logic       green_led;
    logic       red_led;
    logic       locked_out;
    logic [1:0] fail_cnt;

    int n_pass;
    int n_total;

    code_lock_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .key_valid  (key_valid),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .green_led  (green_led),
        .red_led    (red_led),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key       = 4'h0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    task automatic pulse_prog();
        prog_req = 1'b1;
        @(posedge clk);
        #1;
        prog_req = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        key       = 4'h0;
        key_valid = 1'b0;
        prog_req  = 1'b0;

        // Reset state
        idle(2);
        check("rst_unlock", unlock, 0);
        check("rst_green", green_led, 0);
        check("rst_red", red_led, 0);
        check("rst_locked", locked_out, 0);
        check("rst_fail", fail_cnt, 0);
        reset = 1'b0;
        idle(1);

        // Correct default code, keys spaced two cycles apart
        press(4'h1); idle(1);
        press(4'h5); idle(1);
        press(4'h7); idle(1);
        check("pre_unlock", unlock, 0);
        press(4'hF);
        check("unlock_first", unlock, 1);
        check("unlock_green", green_led, 1);
        idle(9);
        check("unlock_last", unlock, 1);
        idle(1);
        check("unlock_end", unlock, 0);

        // Wrong code: no early abort, error one cycle after the 4th key
        press(4'h1); press(4'h5); press(4'h3);
        check("no_abort_red", red_led, 0);
        press(4'hF);
        check("bad_red", red_led, 1);
        check("bad_fail1", fail_cnt, 1);
        check("bad_unlock", unlock, 0);
        idle(1);
        check("err_one_cycle", red_led, 0);

        // Entry timeout after one key
        press(4'h1);
        idle(9);
        check("to_not_yet", red_led, 0);
        idle(1);
        check("to_red", red_led, 1);
        check("to_fail2", fail_cnt, 2);
        idle(1);

        // Key on the expiry cycle is accepted
        press(4'h1);
        idle(9);
        press(4'h5);
        check("late_key_red", red_led, 0);
        press(4'h7);
        press(4'hF);
        check("late_unlock", unlock, 1);
        check("late_fail_clr", fail_cnt, 0);
        press(4'h3);
        check("key_ign_success", unlock, 1);

        // Reprogram to 2,2,2,2
        pulse_prog();
        check("prog_green", green_led, 1);
        check("prog_unlock", unlock, 0);
        enter4(4'h2, 4'h2, 4'h2, 4'h2);
        check("prog_done_green", green_led, 0);
        pulse_prog();
        check("prog_ign_idle", green_led, 0);

        // Old code now fails, new one unlocks
        enter4(4'h1, 4'h5, 4'h7, 4'hF);
        check("old_code_red", red_led, 1);
        check("old_code_fail", fail_cnt, 1);
        idle(1);
        enter4(4'h2, 4'h2, 4'h2, 4'h2);
        check("new_code_unlock", unlock, 1);

        // Abandoned programming keeps the committed code
        pulse_prog();
        press(4'h9);
        press(4'h9);
        idle(9);
        check("prog_hold", green_led, 1);
        idle(1);
        check("prog_to_green", green_led, 0);
        check("prog_to_red", red_led, 0);
        check("prog_to_fail", fail_cnt, 0);
        enter4(4'h2, 4'h2, 4'h2, 4'h2);
        check("kept_code_unlock", unlock, 1);
        idle(10);
        check("kept_code_end", unlock, 0);

`ifdef CODE_LOCK_LOCKOUT_EN
        // Three failures lock the keypad for 50 cycles
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4);
        check("lk_fail3", fail_cnt, 3);
        idle(1);
        check("lk_locked", locked_out, 1);
        check("lk_red", red_led, 1);
        enter4(4'h2, 4'h2, 4'h2, 4'h2);
        check("lk_ignore_unlock", unlock, 0);
        check("lk_ignore_locked", locked_out, 1);
        idle(45);
        check("lk_last", locked_out, 1);
        idle(1);
        check("lk_exit", locked_out, 0);
        check("lk_exit_fail", fail_cnt, 0);
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(6);
        check("lk2_locked", locked_out, 1);
        reset = 1'b1;
        #2;
        check("lk_rst_locked", locked_out, 0);
        check("lk_rst_fail", fail_cnt, 0);
        check("lk_rst_red", red_led, 0);
        reset = 1'b0;
        idle(1);
`else
        // Failure count saturates, no lockout
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4); idle(1);
        enter4(4'h4, 4'h4, 4'h4, 4'h4);
        check("sat_fail3", fail_cnt, 3);
        check("sat_no_lock", locked_out, 0);
        idle(1);
        check("sat_idle_red", red_led, 0);
        enter4(4'h4, 4'h4, 4'h4, 4'h4);
        check("sat_fail_hold", fail_cnt, 3);
        idle(1);
`endif

        // Asynchronous reset mid-entry restores the default code
        press(4'h2);
        press(4'h2);
        reset = 1'b1;
        #2;
        check("mid_rst_fail", fail_cnt, 0);
        check("mid_rst_unlock", unlock, 0);
        reset = 1'b0;
        idle(1);
        enter4(4'h2, 4'h2, 4'h2, 4'h2);
        check("rst_code_old_red", red_led, 1);
        idle(1);
        enter4(4'h1, 4'h5, 4'h7, 4'hF);
        check("rst_code_default", unlock, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CODE_LEN, 4, keys per code.
- KEY_W, 4, key bus width.
- DEFAULT_CODE, {4'h1,4'h5,4'h7,4'hF}, reset code; first key in MS slot.
- ENTRY_TIMEOUT, 10, max idle cycles between keys.
- UNLOCK_TIME, 10, unlock hold cycles.
- MAX_FAIL, 3, consecutive failures before lockout.
- LOCKOUT_TIME, 50, lockout cycles.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 clock.
- reset in 1 reset, asynchronous, active-high.
- key in KEY_W key value.
- key_valid in 1 one-cycle key strobe.
- prog_req in 1 request code reprogramming.
- unlock out 1 door open.
- green_led out 1 success/program indicator.
- red_led out 1 error/lockout indicator.
- locked_out out 1 lockout active.
- fail_cnt out $clog2(MAX_FAIL+1) consecutive failures.

Function
REQ-003 FSM states SHALL be IDLE, ENTRY, SUCCESS, ERROR, PROG, LOCKOUT; all outputs registered/Moore-decoded from state, valid the cycle the state is entered.
REQ-004 IDLE: key_valid stores key in slot 0, sets index=1, loads timer=ENTRY_TIMEOUT, goes ENTRY; no key -> stay.
REQ-005 ENTRY: each key_valid compares key to stored slot[index], sets sticky mismatch on inequality, increments index, reloads timer; entry never aborts early on mismatch.
REQ-006 On CODE_LEN-th key: mismatch clear -> SUCCESS with timer=UNLOCK_TIME; else -> ERROR.
REQ-007 ENTRY timer reaching 0 with no key -> ERROR; key_valid on expiry cycle SHALL win (key accepted, timer reloaded).
REQ-008 ERROR: exactly one cycle, red_led=1, fail_cnt increments (saturating at MAX_FAIL), then IDLE.
REQ-009 SUCCESS: unlock=green_led=1, fail_cnt cleared on entry; timer expiry -> IDLE; prog_req=1 -> PROG, index=0, timer=ENTRY_TIMEOUT.
REQ-010 PROG: green_led=1, unlock=0; keys fill a shadow code; after CODE_LEN keys shadow commits to code register in one cycle, then IDLE.
REQ-011 PROG timeout SHALL discard shadow, keep old code, go IDLE, not count a failure.
REQ-012 key_valid in SUCCESS, ERROR, LOCKOUT SHALL be ignored; prog_req outside SUCCESS ignored.
REQ-013 Timer is a single down-counter, width $clog2(max(ENTRY_TIMEOUT,UNLOCK_TIME,LOCKOUT_TIME)+1), never wraps below 0.

Reset
REQ-014 reset SHALL asynchronously force IDLE, index=0, mismatch=0, timer=0, fail_cnt=0, code=DEFAULT_CODE, all outputs 0, including mid-entry, mid-PROG (no commit) and mid-lockout.

Configuration
REQ-015 With CODE_LOCK_LOCKOUT_EN defined: ERROR with fail_cnt reaching MAX_FAIL SHALL go LOCKOUT (timer=LOCKOUT_TIME, red_led=locked_out=1), exit to IDLE with fail_cnt=0.
REQ-016 Without CODE_LOCK_LOCKOUT_EN: no LOCKOUT state logic, locked_out tied 0, fail_cnt still counts and saturates.

Structure
REQ-017 Package code_lock_pkg SHALL hold the state enum and timer-width helper function.
REQ-018 Timer SHALL be sub-module code_lock_timer (load, value, tick-down, zero flag).

Verification
REQ-019 Keys 1,5,7,F spaced 2 cycles -> unlock=1 the cycle after F for 10 cycles, then IDLE.
REQ-020 Keys 1,5,3,F -> no early abort; ERROR one cycle after 4th key, red_led pulse, fail_cnt=1.
REQ-021 Key 1 then 11 idle cycles -> ERROR; key on 10th idle cycle -> accepted, no error.
REQ-022 Unlock, prog_req, keys 2,2,2,2 -> old code fails, 2,2,2,2 unlocks; PROG abandoned after 2 keys -> old code kept.
REQ-023 LOCKOUT_EN: 3 wrong codes -> locked_out=1 50 cycles, correct code ignored; reset mid-lockout -> IDLE, fail_cnt=0.
